// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes driven by the ALU control decoder
// and the execution-unit state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } alu_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH
// bits of a*b available on the cycle done is high.
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] addend;
    logic [CW-1:0]    count;
    logic             active;

    // product already includes the current step, so the final sum is
    // visible during the last BUSY cycle rather than one cycle later
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = active && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                active <= 1'b0;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready on operands and results; single-cycle
// add/sub/and/slt plus an iterative multiply.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    import alu_pkg::*;

    alu_state_t       state;
    alu_state_t       next_state;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] simple_value;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    assign in_ready  = (state == IDLE);
    assign res_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (alu_control == ALU_MUL);
    assign result    = result_q;
    assign zero      = zero_q;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (src_a),
        .b       (src_b),
        .product (mul_product),
        .done    (mul_done)
    );

    // Unrecognised codes fall through to add
    always_comb begin
        simple_value = src_a + src_b;
        case (alu_control)
            ALU_SUB: simple_value = src_a - src_b;
            ALU_AND: simple_value = src_a & src_b;
            ALU_SLT: simple_value = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: simple_value = src_a + src_b;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = is_mul ? BUSY : DONE;
            BUSY: if (mul_done) next_state = DONE;
            DONE: if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Result register only moves when an operation completes, so it holds
    // steady throughout DONE regardless of input activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (accept && !is_mul) begin
            result_q <= simple_value;
            zero_q   <= (simple_value == '0);
        end else if (state == BUSY && mul_done) begin
            result_q <= mul_product;
            zero_q   <= (mul_product == '0);
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    int vectors;
    int miscompares;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drive one operation for one cycle; returns at the negedge after the
    // accepting posedge (cycle N+1).
    task automatic issue_op(input logic [2:0] code, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b);
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = code;
        src_a       = a;
        src_b       = b;
        @(negedge clk);
        in_valid    = 1'b0;
        src_a       = '0;
        src_b       = '0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        alu_control = 3'b000;
        src_a = '0;
        src_b = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || zero !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset: in_ready=%b res_valid=%b result=%h zero=%b, required 1 0 00000000 1",
                     in_ready, res_valid, result, zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_simple_ops();
        logic [2:0]       codes [7] = '{3'b010, 3'b100, 3'b110, 3'b101, 3'b101, 3'b111, 3'b010};
        logic [WIDTH-1:0] as    [7] = '{32'hFFFF_FFFF, 32'd5, 32'hF0F0_00FF, 32'hFFFF_FFFF, 32'd1, 32'd3, 32'h8000_0000};
        logic [WIDTH-1:0] bs    [7] = '{32'd1, 32'd7, 32'h0FF0_0F0F, 32'd1, 32'hFFFF_FFFF, 32'd4, 32'h8000_0001};
        logic [WIDTH-1:0] exps  [7] = '{32'h0, 32'hFFFF_FFFE, 32'h00F0_000F, 32'd1, 32'd0, 32'd7, 32'd1};
        logic             zexp  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue_op(codes[i], as[i], bs[i]);
            vectors++;
            if (res_valid !== 1'b1 || result !== exps[i] || zero !== zexp[i]) begin
                miscompares++;
                $display("[TB] FAIL simple_op[%0d] code=%b: res_valid=%b result=%h zero=%b, required 1 %h %b",
                         i, codes[i], res_valid, result, zero, exps[i], zexp[i]);
            end
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL simple_handoff[%0d]: in_ready=%b res_valid=%b, required 1 0",
                         i, in_ready, res_valid);
            end
        end
    endtask

    task automatic test_mul();
        logic [WIDTH-1:0] as   [2] = '{32'd7, 32'h0001_0000};
        logic [WIDTH-1:0] bs   [2] = '{32'd6, 32'h0001_0000};
        logic [WIDTH-1:0] exps [2] = '{32'd42, 32'd0};
        logic             zexp [2] = '{1'b0, 1'b1};
        int busy_errs;
        res_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue_op(3'b011, as[i], bs[i]);
            busy_errs = 0;
            for (int k = 1; k <= WIDTH; k++) begin
                if (in_ready !== 1'b0 || res_valid !== 1'b0) busy_errs++;
                @(negedge clk);
            end
            vectors++;
            if (busy_errs != 0) begin
                miscompares++;
                $display("[TB] FAIL mul_busy[%0d]: %0d busy cycles had in_ready/res_valid set, required 0",
                         i, busy_errs);
            end
            vectors++;
            if (res_valid !== 1'b1 || result !== exps[i] || zero !== zexp[i]) begin
                miscompares++;
                $display("[TB] FAIL mul_result[%0d]: res_valid=%b result=%h zero=%b, required 1 %h %b",
                         i, res_valid, result, zero, exps[i], zexp[i]);
            end
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mul_handoff[%0d]: in_ready=%b res_valid=%b, required 1 0",
                         i, in_ready, res_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int hold_errs;
        res_ready = 1'b0;
        issue_op(3'b010, 32'd100, 32'd23);
        hold_errs = 0;
        for (int k = 0; k < 10; k++) begin
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd123 || zero !== 1'b0)
                hold_errs++;
            in_valid    = k[0];
            alu_control = 3'b100;
            src_a       = 32'd9;
            src_b       = 32'd9;
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (hold_errs != 0 || result !== 32'd123) begin
            miscompares++;
            $display("[TB] FAIL backpressure_hold: %0d bad cycles, result=%h, required 0 bad, 0000007b",
                     hold_errs, result);
        end
        res_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || result !== 32'd123) begin
            miscompares++;
            $display("[TB] FAIL backpressure_release: in_ready=%b res_valid=%b result=%h, required 1 0 0000007b",
                     in_ready, res_valid, result);
        end
        @(negedge clk);
        vectors++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL backpressure_no_ghost: res_valid=%b in_ready=%b, required 0 1",
                     res_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_mul();
        int rise_cnt;
        res_ready = 1'b1;
        issue_op(3'b011, 32'd7, 32'd6);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || zero !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_mul: in_ready=%b res_valid=%b result=%h zero=%b, required 1 0 00000000 1",
                     in_ready, res_valid, result, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rise_cnt = 0;
        for (int k = 0; k < WIDTH + 8; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) rise_cnt++;
        end
        vectors++;
        if (rise_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: res_valid high in %0d cycles, required 0", rise_cnt);
        end
        issue_op(3'b010, 32'd2, 32'd2);
        vectors++;
        if (res_valid !== 1'b1 || result !== 32'd4 || zero !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_add: res_valid=%b result=%h zero=%b, required 1 00000004 0",
                     res_valid, result, zero);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_simple_ops();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
